// File: rtl/sar_pkg.sv
// Shared types and helpers for the successive-approximation search controller.
package sar_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        VERIFY = 2'd2
    } state_t;

    // Returns a mask with only bit idx set; zero when idx is out of range.
    function automatic logic [31:0] onehot(input int unsigned idx, input int unsigned width);
        return (idx < width) ? (32'd1 << idx) : 32'd0;
    endfunction

endpackage

// File: rtl/sar_onehot_dec.sv
// Bit-index to one-hot mask decoder for the search controller.
module sar_onehot_dec
    import sar_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IDX_W = 2
) (
    input  logic [IDX_W-1:0] idx,
    output logic [WIDTH-1:0] mask
);

    assign mask = WIDTH'(onehot(32'(idx), 32'(WIDTH)));

endmodule

// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller driving an external magnitude comparator.
// Optional SAR_EARLY_EXIT_EN: finish the search as soon as the comparator reports equality.
module sar_search_ctrl
    import sar_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cmp_gt,
    input  logic             cmp_lt,
    input  logic             cmp_eq,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             found
);

    localparam int IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [IdxW-1:0]  bitIdx;
    logic [WIDTH-1:0] bitMask;

    sar_onehot_dec #(
        .WIDTH (WIDTH),
        .IDX_W (IdxW)
    ) uDec (
        .idx  (bitIdx),
        .mask (bitMask)
    );

    // Decoded purely from registered state so the comparator sees a clean value.
    always_comb begin
        trial = '0;
        case (state)
            SEARCH:  trial = acc | bitMask;
            VERIFY:  trial = acc;
            default: trial = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            acc    <= '0;
            bitIdx <= IdxW'(WIDTH - 1);
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            found  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc    <= '0;
                        bitIdx <= IdxW'(WIDTH - 1);
                        busy   <= 1'b1;
                        state  <= SEARCH;
                    end
                end
                SEARCH: begin
`ifdef SAR_EARLY_EXIT_EN
                    if (cmp_eq) begin
                        result <= trial;
                        found  <= 1'b1;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else begin
`else
                    begin
`endif
                        if (cmp_gt | cmp_eq) begin
                            acc <= acc | bitMask;
                        end
                        if (bitIdx == '0) begin
                            state <= VERIFY;
                        end else begin
                            bitIdx <= bitIdx - IdxW'(1);
                        end
                    end
                end
                VERIFY: begin
                    result <= acc;
                    found  <= cmp_eq & ~cmp_gt & ~cmp_lt;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Scoreboard bench for sar_search_ctrl paired with a 4-bit comparator model.
module tb_sar_search_ctrl;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] res;
        logic         fnd;
        int           lat;
        int           startCyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         cmp_gt, cmp_lt, cmp_eq;
    logic [W-1:0] trial;
    logic         busy, done;
    logic [W-1:0] result;
    logic         found;

    logic [W-1:0] aVal;
    logic         ovr;
    logic [2:0]   ovrFlags;
    int           cyc = 0;
    int           checks = 0;
    int           failures = 0;
    exp_t         sb[$];

    assign cmp_gt = ovr ? ovrFlags[2] : (aVal > trial);
    assign cmp_lt = ovr ? ovrFlags[1] : (aVal < trial);
    assign cmp_eq = ovr ? ovrFlags[0] : (aVal == trial);

    sar_search_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .cmp_gt (cmp_gt),
        .cmp_lt (cmp_lt),
        .cmp_eq (cmp_eq),
        .trial  (trial),
        .busy   (busy),
        .done   (done),
        .result (result),
        .found  (found)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference search against a static operand.
    task automatic model(input logic [W-1:0] a, output logic [W-1:0] res, output logic fnd,
                         output int lat, output logic [W-1:0] tr[W]);
        logic [W-1:0] acc;
        logic [W-1:0] t;
        bit           hit;
        acc = '0;
        hit = 0;
        lat = W + 1;
        res = '0;
        fnd = 1'b0;
        for (int i = 0; i < W; i++) tr[i] = '0;
        for (int b = W - 1; b >= 0; b--) begin
            if (!hit) begin
                t = acc | (W'(1) << b);
                tr[W-1-b] = t;
`ifdef SAR_EARLY_EXIT_EN
                if (a == t) begin
                    hit = 1;
                    res = t;
                    fnd = 1'b1;
                    lat = W - b;
                end
`endif
                if (!hit && a >= t) acc = t;
            end
        end
        if (!hit) begin
            res = acc;
            fnd = (acc == a);
        end
    endtask

    task automatic start_search(input logic [W-1:0] a, input logic [W-1:0] er, input logic ef,
                                input int el);
        exp_t e;
        aVal  = a;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e.res = er;
        e.fnd = ef;
        e.lat = el;
        e.startCyc = cyc;
        sb.push_back(e);
    endtask

    task automatic start_model(input logic [W-1:0] a);
        logic [W-1:0] r;
        logic         f;
        int           l;
        logic [W-1:0] tr[W];
        model(a, r, f, l, tr);
        start_search(a, r, f, l);
    endtask

    task automatic wait_done(input string name);
        exp_t e;
        int   n;
        n = 0;
        while (n < 20 && !done) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s timeout: done not seen in %0d cycles, required within %0d",
                     name, n, W + 1);
        end else if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s unexpected done: got done=1, required no pending search", name);
        end else begin
            e = sb.pop_front();
            checks += 3;
            if (result !== e.res) begin
                failures++;
                $display("FAIL %s result: got %b, required %b", name, result, e.res);
            end
            if (found !== e.fnd) begin
                failures++;
                $display("FAIL %s found: got %b, required %b", name, found, e.fnd);
            end
            if (cyc - e.startCyc !== e.lat) begin
                failures++;
                $display("FAIL %s latency: got %0d edges, required %0d", name, cyc - e.startCyc,
                         e.lat);
            end
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if (trial !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL %s idle outputs: got trial=%b busy=%b done=%b, required 0/0/0",
                     name, trial, busy, done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        checks++;
        if (result !== '0 || found !== 1'b0) begin
            failures++;
            $display("FAIL reset result/found: got %b/%b, required 0000/0", result, found);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_idle_outputs("reset_idle");
    endtask

    task automatic test_trials(input logic [W-1:0] a, input string name);
        logic [W-1:0] r;
        logic         f;
        int           l;
        logic [W-1:0] tr[W];
        model(a, r, f, l, tr);
        start_search(a, r, f, l);
        for (int i = 0; i < W && i < l; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            checks++;
            if (trial !== tr[i] || busy !== 1'b1) begin
                failures++;
                $display("FAIL %s trial step %0d: got trial=%b busy=%b, required %b busy=1",
                         name, i, trial, busy, tr[i]);
            end
        end
        if (l == W + 1) begin
            @(posedge clk);
            #1;
            checks++;
            if (trial !== r) begin
                failures++;
                $display("FAIL %s verify trial: got %b, required %b", name, trial, r);
            end
        end
        wait_done(name);
    endtask

    task automatic test_flip();
        start_search(4'b1011, 4'b1000, 1'b0, W + 1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        aVal = 4'b0100;
        wait_done("flip");
    endtask

    task automatic test_busy_restart();
        bit sawExtra;
        start_model(4'b0110);
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("busy_restart");
        sawExtra = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done || busy) sawExtra = 1;
        end
        checks++;
        if (sawExtra) begin
            failures++;
            $display("FAIL busy_restart queued: got extra activity=1, required 0");
        end
    endtask

    task automatic test_back_to_back();
        start_model(4'b0011);
        wait_done("b2b_first");
        start_model(4'b1101);
        wait_done("b2b_second");
    endtask

    task automatic test_illegal_flags();
        ovr = 1'b1;
        ovrFlags = 3'b000;
        start_search(4'b0000, 4'b0000, 1'b0, W + 1);
        wait_done("flags_none");
        ovrFlags = 3'b111;
`ifdef SAR_EARLY_EXIT_EN
        start_search(4'b0000, 4'b1000, 1'b1, 1);
`else
        start_search(4'b0000, 4'b1111, 1'b0, W + 1);
`endif
        wait_done("flags_all");
        ovr = 1'b0;
    endtask

    task automatic test_mid_reset();
        bit sawDone;
        start_model(4'b1011);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_reset");
        checks++;
        if (result !== '0 || found !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset result/found: got %b/%b, required 0000/0", result, found);
        end
        sb.delete();
        sawDone = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (done) sawDone = 1;
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        if (done) sawDone = 1;
        checks++;
        if (sawDone) begin
            failures++;
            $display("FAIL mid_reset done pulse: got done=1, required 0");
        end
        start_model(4'b0110);
        wait_done("after_reset");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        aVal = '0;
        ovr = 1'b0;
        ovrFlags = 3'b000;
        test_reset();
        test_trials(4'b1011, "a_1011");
        test_trials(4'b0000, "a_0000");
        test_trials(4'b1111, "a_1111");
        test_trials(4'b1000, "a_1000");
        test_flip();
        test_busy_restart();
        test_back_to_back();
        test_illegal_flags();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
